// File: rtl/overlap_add_if.sv
// Sample-stream bundle for overlap_add: frame samples in, reconstructed samples out.
interface overlap_add_if #(
  parameter int unsigned I_BW       = 14,
  parameter int unsigned O_BW       = 16,
  parameter int unsigned OUT_CNT_BW = 17
);
  logic                   di_en;
  logic signed [I_BW-1:0] data_i;
  logic                   flush;
  logic                   di_rdy;
  logic                   do_en;
  logic signed [O_BW-1:0] data_o;
  logic [OUT_CNT_BW-1:0]  out_num;
  logic                   busy;

  modport master (
    output di_en, data_i, flush,
    input  di_rdy, do_en, data_o, out_num, busy
  );

  modport slave (
    input  di_en, data_i, flush,
    output di_rdy, do_en, data_o, out_num, busy
  );
endinterface

// File: rtl/overlap_add.sv
// Overlap-add resynthesis: sums HOP_LEN-spaced frames into a circular accumulator
// and emits HOP_LEN finished samples per frame, with a flush to drain the tail.
module overlap_add #(
  parameter int unsigned I_BW       = 14,
  parameter int unsigned O_BW       = 16,
  parameter int unsigned FRAME_LEN  = 1024,
  parameter int unsigned HOP_LEN    = 160,
  parameter int unsigned OUT_CNT_BW = 17
) (
  input logic          clk,
  input logic          rst,
  overlap_add_if.slave bus
);

  localparam int unsigned ACC_BW = I_BW + $clog2((FRAME_LEN + HOP_LEN - 1) / HOP_LEN);
  localparam int unsigned IDX_BW = $clog2(FRAME_LEN);
  localparam int unsigned SUM_BW = IDX_BW + 1;
  localparam int unsigned SAT_W  = (ACC_BW > O_BW) ? ACC_BW : O_BW;

  localparam logic signed [SAT_W-1:0] SAT_HI = SAT_W'({1'b0, {(O_BW-1){1'b1}}});
  localparam logic signed [SAT_W-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {ACCUM, DRAIN, FLUSH} state_t;

  state_t                   state;
  logic [IDX_BW-1:0]        base;
  logic [IDX_BW-1:0]        k;
  logic [IDX_BW-1:0]        j;
  logic signed [ACC_BW-1:0] acc [FRAME_LEN];
  logic [IDX_BW-1:0]        wr_idx;
  logic [IDX_BW-1:0]        rd_idx;
  logic [IDX_BW-1:0]        j_last;

  // Circular addressing; both operands are already below FRAME_LEN.
  function automatic logic [IDX_BW-1:0] wrap_add(input logic [IDX_BW-1:0] a,
                                                  input logic [IDX_BW-1:0] b);
    logic [SUM_BW-1:0] s;
    s = SUM_BW'(a) + SUM_BW'(b);
    if (s >= SUM_BW'(FRAME_LEN)) s = s - SUM_BW'(FRAME_LEN);
    return s[IDX_BW-1:0];
  endfunction

  function automatic logic signed [O_BW-1:0] sat(input logic signed [ACC_BW-1:0] a);
    logic signed [SAT_W-1:0] ax;
    ax = SAT_W'(a);
    if (ax > SAT_HI)      return SAT_HI[O_BW-1:0];
    else if (ax < SAT_LO) return SAT_LO[O_BW-1:0];
    else                  return ax[O_BW-1:0];
  endfunction

  assign wr_idx = wrap_add(base, k);
  assign rd_idx = wrap_add(base, j);
  assign j_last = (state == DRAIN) ? IDX_BW'(HOP_LEN - 1) : IDX_BW'(FRAME_LEN - HOP_LEN - 1);

  // A pending flush at a frame boundary blocks new samples so the tail drains cleanly.
  assign bus.di_rdy = (state == ACCUM) && !(bus.flush && (k == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACCUM;
      base        <= '0;
      k           <= '0;
      j           <= '0;
      bus.do_en   <= 1'b0;
      bus.data_o  <= '0;
      bus.out_num <= '0;
      bus.busy    <= 1'b0;
      for (int i = 0; i < int'(FRAME_LEN); i++) acc[i] <= '0;
    end else begin
      bus.do_en <= 1'b0;
      unique case (state)
        ACCUM: begin
          if (bus.flush && (k == '0)) begin
            j        <= '0;
            state    <= FLUSH;
            bus.busy <= 1'b1;
          end else if (bus.di_en) begin
            acc[wr_idx] <= acc[wr_idx] + ACC_BW'(bus.data_i);
            if (k == IDX_BW'(FRAME_LEN - 1)) begin
              k        <= '0;
              j        <= '0;
              state    <= DRAIN;
              bus.busy <= 1'b1;
            end else begin
              k <= k + IDX_BW'(1);
            end
          end
        end
        DRAIN, FLUSH: begin
          // Each finished slot is cleared as it leaves so it can start the next frame's sum.
          bus.data_o  <= sat(acc[rd_idx]);
          bus.do_en   <= 1'b1;
          bus.out_num <= bus.out_num + OUT_CNT_BW'(1);
          acc[rd_idx] <= '0;
          if (j == j_last) begin
            j        <= '0;
            state    <= ACCUM;
            bus.busy <= 1'b0;
            base     <= (state == DRAIN) ? wrap_add(base, IDX_BW'(HOP_LEN)) : '0;
          end else begin
            j <= j + IDX_BW'(1);
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_overlap_add.sv
// Bench for overlap_add: two instances (O_BW 16 and 14) share stimulus and are
// checked against an absolute-position overlap-add reference model.
module tb_overlap_add;

  localparam int FRAME = 8;
  localparam int HOP   = 2;
  localparam int IBW   = 14;
  localparam int CBW   = 17;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  overlap_add_if #(.I_BW(IBW), .O_BW(16), .OUT_CNT_BW(CBW)) b16 ();
  overlap_add_if #(.I_BW(IBW), .O_BW(14), .OUT_CNT_BW(CBW)) b14 ();

  overlap_add #(.I_BW(IBW), .O_BW(16), .FRAME_LEN(FRAME), .HOP_LEN(HOP), .OUT_CNT_BW(CBW))
    dut16 (.clk(clk), .rst(rst), .bus(b16.slave));
  overlap_add #(.I_BW(IBW), .O_BW(14), .FRAME_LEN(FRAME), .HOP_LEN(HOP), .OUT_CNT_BW(CBW))
    dut14 (.clk(clk), .rst(rst), .bus(b14.slave));

  int checks;
  int errors;

  // Reference: reconstructed stream indexed by absolute sample position.
  int recon [int];
  int pend [$];
  int frame_start, out_pos, k_m, out_cnt, busy_cnt;
  bit flush_taken;
  int log16 [$];
  int log14 [$];

  function automatic int getr(input int p);
    return recon.exists(p) ? recon[p] : 0;
  endfunction

  function automatic int satv(input int v, input int w);
    int hi, lo;
    hi = (1 <<< (w - 1)) - 1;
    lo = -(1 <<< (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int got[$], input int exp[$]);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++) chk(tag, got[i], exp[i]);
  endtask

  task automatic clear_logs();
    log16.delete();
    log14.delete();
  endtask

  task automatic step(input bit en, input int d, input bit fl, input bit r, output bit accepted);
    bit exp_rdy, exp_en;
    int exp_data;
    b16.di_en = en;       b14.di_en = en;
    b16.data_i = IBW'(d); b14.data_i = IBW'(d);
    b16.flush = fl;       b14.flush = fl;
    rst = r;
    #1;
    exp_rdy = (pend.size() == 0) && !(fl && k_m == 0);
    if (!r) begin
      chk("di_rdy16", 32'(b16.di_rdy), 32'(exp_rdy));
      chk("di_rdy14", 32'(b14.di_rdy), 32'(exp_rdy));
    end
    accepted = 1'b0;
    exp_en = 1'b0;
    exp_data = 0;
    if (r) begin
      recon.delete(); pend.delete();
      frame_start = 0; out_pos = 0; k_m = 0; out_cnt = 0;
    end else if (pend.size() > 0) begin
      exp_en = 1'b1;
      exp_data = pend.pop_front();
      out_cnt = (out_cnt + 1) % (1 << CBW);
    end else if (fl && k_m == 0) begin
      for (int i = 0; i < FRAME - HOP; i++) pend.push_back(getr(out_pos + i));
      recon.delete();
      out_pos = 0; frame_start = 0;
      flush_taken = 1'b1;
    end else if (en) begin
      accepted = 1'b1;
      recon[frame_start + k_m] = getr(frame_start + k_m) + d;
      k_m++;
      if (k_m == FRAME) begin
        for (int i = 0; i < HOP; i++) pend.push_back(getr(out_pos + i));
        out_pos += HOP;
        frame_start += HOP;
        k_m = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("do_en16", 32'(b16.do_en), 32'(exp_en));
    chk("do_en14", 32'(b14.do_en), 32'(exp_en));
    if (exp_en) begin
      chk("data16", 32'($signed(b16.data_o)), satv(exp_data, 16));
      chk("data14", 32'($signed(b14.data_o)), satv(exp_data, 14));
    end
    if (r) begin
      chk("rst_data16", 32'($signed(b16.data_o)), 0);
      chk("rst_data14", 32'($signed(b14.data_o)), 0);
    end
    chk("out_num16", 32'(b16.out_num), out_cnt);
    chk("out_num14", 32'(b14.out_num), out_cnt);
    chk("busy16", 32'(b16.busy), 32'(pend.size() != 0));
    chk("busy14", 32'(b14.busy), 32'(pend.size() != 0));
    if (b16.do_en === 1'b1) log16.push_back(32'($signed(b16.data_o)));
    if (b14.do_en === 1'b1) log14.push_back(32'($signed(b14.data_o)));
    if (b16.busy === 1'b1) busy_cnt++;
  endtask

  // mode 0: constant val, mode 1: random samples; flush held from sample index flush_from.
  task automatic send_frame(input int mode, input int val, input int gap_pct, input int flush_from);
    int n, guard, d;
    bit a, fl;
    n = 0;
    guard = 0;
    while (n < FRAME && guard < 200) begin
      d = (mode == 1) ? (int'($urandom_range(16383)) - 8192) : val;
      fl = (flush_from >= 0) && (n >= flush_from);
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) step(1'b0, d, fl, 1'b0, a);
      else step(1'b1, d, fl, 1'b0, a);
      if (a) n++;
      guard++;
    end
    chk("frame_complete", n, FRAME);
  endtask

  task automatic drain();
    int g;
    bit a;
    g = 0;
    while (pend.size() > 0 && g < 4 * FRAME) begin
      step(1'b0, 0, 1'b0, 1'b0, a);
      g++;
    end
    chk("drain_done", pend.size(), 0);
  endtask

  task automatic do_flush();
    int g;
    bit a;
    g = 0;
    flush_taken = 1'b0;
    while (!flush_taken && g < 4 * FRAME) begin
      step(1'b0, 0, 1'b1, 1'b0, a);
      g++;
    end
    chk("flush_start", 32'(flush_taken), 1);
    drain();
  endtask

  task automatic do_reset();
    bit a;
    step(1'b0, 0, 1'b0, 1'b1, a);
    step(1'b0, 0, 1'b0, 1'b1, a);
  endtask

  initial begin
    bit a;
    int e [$];
    checks = 0; errors = 0; busy_cnt = 0;
    recon.delete(); pend.delete();
    frame_start = 0; out_pos = 0; k_m = 0; out_cnt = 0;
    do_reset();

    // Back-to-back constant frames; dropped samples during drain exercise di_rdy.
    clear_logs();
    for (int f = 0; f < 6; f++) send_frame(0, 1, 0, -1);
    drain();
    e = '{1, 1, 2, 2, 3, 3, 4, 4, 4, 4, 4, 4};
    chk_log("const16", log16, e);
    chk("out_num_end", 32'(b16.out_num), 12);

    clear_logs();
    busy_cnt = 0;
    do_flush();
    chk("flush_busy_cycles", busy_cnt, FRAME - HOP);
    e = '{3, 3, 2, 2, 1, 1};
    chk_log("flush16", log16, e);
    clear_logs();
    send_frame(0, 1, 0, -1);
    drain();
    e = '{1, 1};
    chk_log("post_flush16", log16, e);

    // Gaps in di_en must not change results.
    do_reset();
    clear_logs();
    for (int f = 0; f < 6; f++) send_frame(0, 1, 40, -1);
    drain();
    e = '{1, 1, 2, 2, 3, 3, 4, 4, 4, 4, 4, 4};
    chk_log("gap16", log16, e);

    // Flush raised mid-frame: drain first, then flush.
    do_reset();
    clear_logs();
    send_frame(0, 1, 0, 3);
    do_flush();
    e = '{1, 1, 1, 1, 1, 1, 1, 1};
    chk_log("late_flush16", log16, e);

    // Saturation at both extremes.
    do_reset();
    clear_logs();
    for (int f = 0; f < 3; f++) send_frame(0, 8191, 0, -1);
    drain();
    e = '{8191, 8191, 8191, 8191, 8191, 8191};
    chk_log("sat_pos14", log14, e);
    e = '{8191, 8191, 16382, 16382, 24573, 24573};
    chk_log("sat_pos16", log16, e);
    do_reset();
    clear_logs();
    for (int f = 0; f < 3; f++) send_frame(0, -8192, 0, -1);
    drain();
    e = '{-8192, -8192, -8192, -8192, -8192, -8192};
    chk_log("sat_neg14", log14, e);
    e = '{-8192, -8192, -16384, -16384, -24576, -24576};
    chk_log("sat_neg16", log16, e);

    // Reset during the second drain cycle discards partial sums.
    do_reset();
    send_frame(0, 1, 0, -1);
    send_frame(0, 1, 0, -1);
    step(1'b0, 0, 1'b0, 1'b0, a);
    step(1'b0, 0, 1'b0, 1'b1, a);
    chk("mid_rst_busy", 32'(b16.busy), 0);
    clear_logs();
    send_frame(0, 1, 0, -1);
    drain();
    e = '{1, 1};
    chk_log("post_rst16", log16, e);

    // Random frames with gaps, a mid-frame flush and a restart.
    do_reset();
    for (int f = 0; f < 5; f++) send_frame(1, 0, 30, -1);
    send_frame(1, 0, 20, 3);
    do_flush();
    send_frame(1, 0, 0, -1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
